// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-client RAM port arbiter.
package ram_arb_pkg;

  typedef enum logic {
    SERVE = 1'b0,
    INIT  = 1'b1
  } state_t;

  localparam int unsigned CLI_A     = 0;
  localparam int unsigned CLI_B     = 1;
  localparam int unsigned GNT_CNT_W = 16;

endpackage

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Two-request round-robin arbiter; the last-grant register starts at B so A wins the first conflict.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  logic last_b;

  always_comb begin
    gnt = 2'b00;
    if (accept) begin
      if (req == 2'b11) begin
        gnt[CLI_A] = last_b;
        gnt[CLI_B] = ~last_b;
      end else begin
        gnt = req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      last_b <= 1'b1;
    end else if (|gnt) begin
      last_b <= gnt[CLI_B];
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one synchronous dual-port RAM between clients A and B, with a zero-fill init sequencer.
// Optional grant counters are built when RAM_ARB_GRANT_CNT_EN is defined.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned RAM_WIDTH = 16,
  parameter int unsigned RAM_DEPTH = 8,
  parameter int unsigned ADDR_SIZE = 3
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 init,
  output logic                 busy,
  input  logic                 req_a,
  input  logic                 req_b,
  input  logic                 we_a,
  input  logic                 we_b,
  input  logic [ADDR_SIZE-1:0] addr_a,
  input  logic [ADDR_SIZE-1:0] addr_b,
  input  logic [RAM_WIDTH-1:0] wdata_a,
  input  logic [RAM_WIDTH-1:0] wdata_b,
  output logic                 ack_a,
  output logic                 ack_b,
  output logic                 rvalid_a,
  output logic                 rvalid_b,
  output logic [RAM_WIDTH-1:0] rdata_a,
  output logic [RAM_WIDTH-1:0] rdata_b,
  output logic                 mem_write,
  output logic                 mem_read,
  output logic [ADDR_SIZE-1:0] mem_wr_addrs,
  output logic [ADDR_SIZE-1:0] mem_rd_addrs,
  output logic [RAM_WIDTH-1:0] mem_data_in,
  input  logic [RAM_WIDTH-1:0] mem_data_out,
  output logic [GNT_CNT_W-1:0] gnt_cnt_a,
  output logic [GNT_CNT_W-1:0] gnt_cnt_b
);

  state_t               state, state_nx;
  logic                 busy_nx;
  logic [ADDR_SIZE-1:0] init_cnt, init_cnt_nx;
  logic                 wr_nx, rd_nx;
  logic [ADDR_SIZE-1:0] wr_addr_nx, rd_addr_nx;
  logic [RAM_WIDTH-1:0] din_nx;
  logic                 accept;
  logic [1:0]           gnt;
  logic                 sel_b;
  logic                 rd_tag1, rd_v2, rd_tag2;

  // init and reset both pre-empt any grant in their cycle
  assign accept = (state == SERVE) && !init && !clr;
  assign ack_a  = gnt[CLI_A];
  assign ack_b  = gnt[CLI_B];
  assign sel_b  = gnt[CLI_B];

  rr_arb2 u_arb (
    .clk    (clk),
    .clr    (clr),
    .req    ({req_b, req_a}),
    .accept (accept),
    .gnt    (gnt)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state        <= SERVE;
      busy         <= 1'b0;
      init_cnt     <= '0;
      mem_write    <= 1'b0;
      mem_read     <= 1'b0;
      mem_wr_addrs <= '0;
      mem_rd_addrs <= '0;
      mem_data_in  <= '0;
    end else begin
      state        <= state_nx;
      busy         <= busy_nx;
      init_cnt     <= init_cnt_nx;
      mem_write    <= wr_nx;
      mem_read     <= rd_nx;
      mem_wr_addrs <= wr_addr_nx;
      mem_rd_addrs <= rd_addr_nx;
      mem_data_in  <= din_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    busy_nx     = busy;
    init_cnt_nx = init_cnt;
    wr_nx       = 1'b0;
    rd_nx       = 1'b0;
    wr_addr_nx  = mem_wr_addrs;
    rd_addr_nx  = mem_rd_addrs;
    din_nx      = mem_data_in;
    case (state)
      SERVE: begin
        if (init) begin
          state_nx    = INIT;
          busy_nx     = 1'b1;
          init_cnt_nx = '0;
        end else if (|gnt) begin
          if (sel_b ? we_b : we_a) begin
            wr_nx      = 1'b1;
            wr_addr_nx = sel_b ? addr_b : addr_a;
            din_nx     = sel_b ? wdata_b : wdata_a;
          end else begin
            rd_nx      = 1'b1;
            rd_addr_nx = sel_b ? addr_b : addr_a;
          end
        end
      end
      INIT: begin
        wr_nx      = 1'b1;
        wr_addr_nx = init_cnt;
        din_nx     = '0;
        if (init_cnt == ADDR_SIZE'(RAM_DEPTH - 1)) begin
          state_nx = SERVE;
          busy_nx  = 1'b0;
        end else begin
          init_cnt_nx = init_cnt + ADDR_SIZE'(1);
        end
      end
      default: state_nx = SERVE;
    endcase
  end

  // Tag follows the read through the RAM's capture stage to steer the result
  always_ff @(posedge clk) begin
    if (clr) begin
      rd_tag1  <= 1'b0;
      rd_v2    <= 1'b0;
      rd_tag2  <= 1'b0;
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
      rdata_a  <= '0;
      rdata_b  <= '0;
    end else begin
      if (rd_nx) rd_tag1 <= sel_b;
      rd_v2    <= mem_read;
      rd_tag2  <= rd_tag1;
      rvalid_a <= rd_v2 && !rd_tag2;
      rvalid_b <= rd_v2 && rd_tag2;
      if (rd_v2 && !rd_tag2) rdata_a <= mem_data_out;
      if (rd_v2 && rd_tag2)  rdata_b <= mem_data_out;
    end
  end

`ifdef RAM_ARB_GRANT_CNT_EN
  logic [GNT_CNT_W-1:0] cnt_a_q, cnt_b_q;

  // Saturating per-client grant counters; init leaves them alone
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      if (ack_a && (cnt_a_q != '1)) cnt_a_q <= cnt_a_q + GNT_CNT_W'(1);
      if (ack_b && (cnt_b_q != '1)) cnt_b_q <= cnt_b_q + GNT_CNT_W'(1);
    end
  end

  assign gnt_cnt_a = cnt_a_q;
  assign gnt_cnt_b = cnt_b_q;
`else
  assign gnt_cnt_a = '0;
  assign gnt_cnt_b = '0;
`endif

endmodule
